rc4_phase_sequencer: RTL and testbench

// Top-level scheduler for the RC4 key-search datapath. Sequences the three phase engines
// (S-init, KSA swap loop, PRGA/decrypt) in fixed order and arbitrates the single-port
// 256x8 S-memory between them. Optionally steps the secret key on decrypt failure for brute force.

---
 rtl/rc4_pkg.sv | 30 +++
 rtl/s_mem_mux.sv | 40 ++++
 rtl/rc4_phase_sequencer.sv | 147 ++++++++++++++
 tb/tb_rc4_phase_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module : rc4_pkg
//  Brief  : Shared types and constants for the RC4 key-search phase sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
package rc4_pkg;

    localparam int S_AW    = 8;
    localparam int S_DW    = 8;
    localparam int N_CL    = 3;

    localparam int CL_INIT = 0;
    localparam int CL_KSA  = 1;
    localparam int CL_PRGA = 2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLEAR    = 4'd1,
        ST_SETTLE   = 4'd2,
        ST_INIT     = 4'd3,
        ST_KSA      = 4'd4,
        ST_PRGA     = 4'd5,
        ST_NEXT_KEY = 4'd6,
        ST_FOUND    = 4'd7,
        ST_FAIL     = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/s_mem_mux.sv
`default_nettype none
// ============================================================================
//  Module : s_mem_mux
//  Brief  : Combinational 3:1 grant mux onto the single-port S-memory.
//  Rev    : 1.0  initial release
// ============================================================================
module s_mem_mux
    import rc4_pkg::*;
(
    input  logic [N_CL-1:0]      i_grant,
    input  logic [N_CL*S_AW-1:0] i_addr,
    input  logic [N_CL*S_DW-1:0] i_wrdata,
    input  logic [N_CL-1:0]      i_wren,
    output logic [S_AW-1:0]      o_addr,
    output logic [S_DW-1:0]      o_wrdata,
    output logic                 o_wren
);

    // Grant is one-hot; with no grant the memory sees a benign idle access.
    always_comb begin
        o_addr   = '0;
        o_wrdata = '0;
        o_wren   = 1'b0;
        if (i_grant[CL_INIT]) begin
            o_addr   = i_addr[CL_INIT*S_AW +: S_AW];
            o_wrdata = i_wrdata[CL_INIT*S_DW +: S_DW];
            o_wren   = i_wren[CL_INIT];
        end else if (i_grant[CL_KSA]) begin
            o_addr   = i_addr[CL_KSA*S_AW +: S_AW];
            o_wrdata = i_wrdata[CL_KSA*S_DW +: S_DW];
            o_wren   = i_wren[CL_KSA];
        end else if (i_grant[CL_PRGA]) begin
            o_addr   = i_addr[CL_PRGA*S_AW +: S_AW];
            o_wrdata = i_wrdata[CL_PRGA*S_DW +: S_DW];
            o_wren   = i_wren[CL_PRGA];
        end
    end

endmodule
`default_nettype wire

// File: rtl/rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : rc4_phase_sequencer
//  Brief  : Runs S-init, KSA and PRGA engines in order, owns the S-memory
//           grant, the brute-force key counter and the per-phase watchdog.
//  Rev    : 1.0  initial release
// ============================================================================
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int               KEY_W    = 24,
    parameter logic [KEY_W-1:0] KEY_MAX  = KEY_W'(24'h3FFFFF),
    parameter int               WDOG_CYC = 8192
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [KEY_W-1:0]     key_init,
    input  logic                 brute_en,
    output logic [N_CL-1:0]      en,
    output logic                 phase_clr,
    input  logic [N_CL-1:0]      cl_done,
    input  logic [N_CL*S_AW-1:0] cl_addr,
    input  logic [N_CL*S_DW-1:0] cl_wrdata,
    input  logic [N_CL-1:0]      cl_wren,
    input  logic                 prga_ok,
    output logic [S_AW-1:0]      s_addr,
    output logic [S_DW-1:0]      s_wrdata,
    output logic                 s_wren,
    output logic [KEY_W-1:0]     key_out,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic                 timeout
);

    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] C_WDOG_LAST = WD_W'(WDOG_CYC - 1);

    state_t           r_state_q,   w_state_d;
    logic [KEY_W-1:0] r_key_q,     w_key_d;
    logic [WD_W-1:0]  r_wdog_q,    w_wdog_d;
    logic             r_timeout_q, w_timeout_d;
    logic [N_CL-1:0]  w_en;
    logic             w_phase_clr;
    logic             w_in_phase;
    logic             w_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_IDLE;
            r_key_q     <= '0;
            r_wdog_q    <= '0;
            r_timeout_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_key_q     <= w_key_d;
            r_wdog_q    <= w_wdog_d;
            r_timeout_q <= w_timeout_d;
        end
    end

    always_comb begin
        w_state_d   = r_state_q;
        w_key_d     = r_key_q;
        w_timeout_d = r_timeout_q;
        w_wdog_d    = '0;
        w_en        = '0;
        w_phase_clr = 1'b0;
        w_in_phase  = 1'b0;
        w_done      = 1'b0;

        case (r_state_q)
            ST_IDLE, ST_FOUND, ST_FAIL: begin
                if (start) begin
                    w_state_d   = ST_CLEAR;
                    w_key_d     = key_init;
                    w_timeout_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                w_phase_clr = 1'b1;
                w_state_d   = ST_SETTLE;
            end
            // Dead cycle so clients can drop their done flags after the clear.
            ST_SETTLE: w_state_d = ST_INIT;
            ST_INIT: begin
                w_en[CL_INIT] = 1'b1;
                w_in_phase    = 1'b1;
                w_done        = cl_done[CL_INIT];
                if (w_done) w_state_d = ST_KSA;
            end
            ST_KSA: begin
                w_en[CL_KSA] = 1'b1;
                w_in_phase   = 1'b1;
                w_done       = cl_done[CL_KSA];
                if (w_done) w_state_d = ST_PRGA;
            end
            ST_PRGA: begin
                w_en[CL_PRGA] = 1'b1;
                w_in_phase    = 1'b1;
                w_done        = cl_done[CL_PRGA];
                if (w_done) begin
                    if (prga_ok)                                w_state_d = ST_FOUND;
                    else if (!brute_en || r_key_q == KEY_MAX)   w_state_d = ST_FAIL;
                    else                                        w_state_d = ST_NEXT_KEY;
                end
            end
            ST_NEXT_KEY: begin
                w_key_d   = r_key_q + 1'b1;
                w_state_d = ST_CLEAR;
            end
            default: w_state_d = ST_IDLE;
        endcase

        // Counter restarts at zero on every phase entry; expiry fires on the
        // WDOG_CYC-th cycle spent in one phase without a granted done.
        if (w_in_phase && !w_done) begin
            if (r_wdog_q == C_WDOG_LAST) begin
                w_state_d   = ST_FAIL;
                w_timeout_d = 1'b1;
            end else begin
                w_wdog_d = r_wdog_q + 1'b1;
            end
        end
    end

    s_mem_mux u_s_mem_mux (
        .i_grant  (w_en),
        .i_addr   (cl_addr),
        .i_wrdata (cl_wrdata),
        .i_wren   (cl_wren),
        .o_addr   (s_addr),
        .o_wrdata (s_wrdata),
        .o_wren   (s_wren)
    );

    assign en        = w_en;
    assign phase_clr = w_phase_clr;
    assign key_out   = r_key_q;
    assign busy      = (r_state_q != ST_IDLE) && (r_state_q != ST_FOUND) && (r_state_q != ST_FAIL);
    assign found     = (r_state_q == ST_FOUND);
    assign exhausted = (r_state_q == ST_FAIL);
    assign timeout   = r_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rc4_phase_sequencer.sv
`default_nettype none
// ============================================================================
//  Module : tb_rc4_phase_sequencer
//  Brief  : Directed self-checking bench for rc4_phase_sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_rc4_phase_sequencer;

    localparam int KEY_W    = 24;
    localparam int WDOG_CYC = 8192;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [KEY_W-1:0]  key_init;
    logic              brute_en;
    logic [2:0]        en;
    logic              phase_clr;
    logic [2:0]        cl_done;
    logic [23:0]       cl_addr;
    logic [23:0]       cl_wrdata;
    logic [2:0]        cl_wren;
    logic              prga_ok;
    logic [7:0]        s_addr;
    logic [7:0]        s_wrdata;
    logic              s_wren;
    logic [KEY_W-1:0]  key_out;
    logic              busy;
    logic              found;
    logic              exhausted;
    logic              timeout;

    int n_total = 0;
    int n_pass  = 0;
    int clr_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst)            clr_cnt <= 0;
        else if (phase_clr) clr_cnt <= clr_cnt + 1;
    end

    rc4_phase_sequencer #(
        .KEY_W    (KEY_W),
        .KEY_MAX  (24'h3FFFFF),
        .WDOG_CYC (WDOG_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_init  (key_init),
        .brute_en  (brute_en),
        .en        (en),
        .phase_clr (phase_clr),
        .cl_done   (cl_done),
        .cl_addr   (cl_addr),
        .cl_wrdata (cl_wrdata),
        .cl_wren   (cl_wren),
        .prga_ok   (prga_ok),
        .s_addr    (s_addr),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .key_out   (key_out),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .timeout   (timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // From CLEAR: release dones, pass SETTLE, arrive in INIT.
    task automatic clear_to_init();
        cl_done = 3'b000;
        step();
        check("settle_en", {29'd0, en}, 32'h0);
        step();
        check("init_en", {29'd0, en}, 32'h1);
    endtask

    // From INIT: clients finish in order; returns one cycle after PRGA done.
    task automatic run_phases(input logic ok);
        cl_done = 3'b001;
        step();
        check("ksa_en", {29'd0, en}, 32'h2);
        cl_done = 3'b011;
        step();
        check("prga_en", {29'd0, en}, 32'h4);
        cl_done = 3'b111;
        prga_ok = ok;
        step();
        prga_ok = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        key_init  = '0;
        brute_en  = 1'b0;
        cl_done   = 3'b000;
        cl_addr   = {8'h77, 8'h55, 8'h10};
        cl_wrdata = {8'hCC, 8'hAA, 8'h33};
        cl_wren   = 3'b010;
        prga_ok   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_en",        {29'd0, en},        32'h0);
        check("rst_phase_clr", {31'd0, phase_clr}, 32'h0);
        check("rst_key",       {8'd0, key_out},    32'h0);
        check("rst_busy",      {31'd0, busy},      32'h0);
        check("rst_flags",     {29'd0, found, exhausted, timeout}, 32'h0);
        check("rst_s_wren",    {31'd0, s_wren},    32'h0);

        // Single successful search.
        key_init = 24'h000249;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("a_clear_pulse", {31'd0, phase_clr}, 32'h1);
        check("a_clear_busy",  {31'd0, busy},      32'h1);
        check("a_key_load",    {8'd0, key_out},    32'h000249);
        check("a_clear_en",    {29'd0, en},        32'h0);
        step();
        check("a_settle_clr",  {31'd0, phase_clr}, 32'h0);
        step();
        check("a_init_en",     {29'd0, en},        32'h1);
        check("a_mux_addr",    {24'd0, s_addr},    32'h10);
        check("a_mux_wren",    {31'd0, s_wren},    32'h0);
        check("a_mux_wrdata",  {24'd0, s_wrdata},  32'h33);
        // Non-granted dones must not advance the phase.
        cl_done = 3'b110;
        step();
        check("a_foreign_done", {29'd0, en}, 32'h1);
        cl_done = 3'b001;
        step();
        check("a_ksa_en",      {29'd0, en},        32'h2);
        check("a_ksa_addr",    {24'd0, s_addr},    32'h55);
        check("a_ksa_wren",    {31'd0, s_wren},    32'h1);
        cl_done = 3'b011;
        step();
        check("a_prga_en",     {29'd0, en},        32'h4);
        check("a_prga_addr",   {24'd0, s_addr},    32'h77);
        start = 1'b1;
        step();
        start = 1'b0;
        check("a_busy_start_ignored", {29'd0, en}, 32'h4);
        cl_done = 3'b111;
        prga_ok = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        prga_ok = 1'b0;
        check("a_found",       {31'd0, found},     32'h1);
        check("a_found_busy",  {31'd0, busy},      32'h0);
        check("a_found_key",   {8'd0, key_out},    32'h000249);
        check("a_found_en",    {29'd0, en},        32'h0);
        check("a_found_wren",  {31'd0, s_wren},    32'h0);
        step();
        check("a_found_hold",  {31'd0, found},     32'h1);
        check("a_clr_count",   clr_cnt,            32'd1);

        // Restart from FOUND in brute-force mode, two failing keys.
        key_init = 24'h3FFFFE;
        brute_en = 1'b1;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("b_found_cleared", {31'd0, found},   32'h0);
        check("b_clear_pulse",   {31'd0, phase_clr}, 32'h1);
        check("b_key_load",      {8'd0, key_out},  32'h3FFFFE);
        clear_to_init();
        run_phases(1'b0);
        check("b_next_busy",   {31'd0, busy},      32'h1);
        check("b_next_key",    {8'd0, key_out},    32'h3FFFFE);
        step();
        check("b_clear2_pulse", {31'd0, phase_clr}, 32'h1);
        check("b_key_inc",     {8'd0, key_out},    32'h3FFFFF);
        clear_to_init();
        run_phases(1'b0);
        check("b_exhausted",   {31'd0, exhausted}, 32'h1);
        check("b_not_found",   {31'd0, found},     32'h0);
        check("b_fail_busy",   {31'd0, busy},      32'h0);
        check("b_no_timeout",  {31'd0, timeout},   32'h0);
        check("b_key_max",     {8'd0, key_out},    32'h3FFFFF);
        check("b_clr_count",   clr_cnt,            32'd3);

        // Watchdog: KSA never completes.
        key_init = 24'h000005;
        brute_en = 1'b0;
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("c_exh_cleared", {31'd0, exhausted}, 32'h0);
        clear_to_init();
        cl_done = 3'b001;
        step();
        check("c_ksa_entry", {29'd0, en}, 32'h2);
        for (int i = 0; i < WDOG_CYC - 1; i++) step();
        check("c_ksa_last_cycle", {29'd0, en},     32'h2);
        check("c_no_timeout_yet", {31'd0, timeout}, 32'h0);
        step();
        check("c_timeout",     {31'd0, timeout},   32'h1);
        check("c_exhausted",   {31'd0, exhausted}, 32'h1);
        check("c_en_off",      {29'd0, en},        32'h0);
        check("c_busy",        {31'd0, busy},      32'h0);

        // Reset in the middle of KSA.
        start = 1'b1;
        step();
        start = 1'b0;
        check("d_timeout_cleared", {31'd0, timeout}, 32'h0);
        clear_to_init();
        cl_done = 3'b001;
        step();
        check("d_ksa_en",   {29'd0, en},     32'h2);
        check("d_ksa_wren", {31'd0, s_wren}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("d_rst_en",    {29'd0, en},     32'h0);
        check("d_rst_wren",  {31'd0, s_wren}, 32'h0);
        check("d_rst_busy",  {31'd0, busy},   32'h0);
        check("d_rst_flags", {29'd0, found, exhausted, timeout}, 32'h0);
        check("d_rst_key",   {8'd0, key_out}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
